// File: rtl/branch_ctrl.sv
// Conditional-branch resolution: captures a B-type branch, resolves taken/target/err, counts branches.
// Latency: 2 cycles from accept to out_valid (capture, then one RESOLVE cycle).
// Backpressure: results are held in HOLD until out_ready; in_ready is low outside IDLE.
module branch_ctrl #(
  parameter int N         = 32,
  parameter int FLUSH_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic         BrEq,
  input  logic         BrLT,
  output logic         BrUn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] target,
  output logic         err,
  output logic         flush,
  output logic [15:0]  br_cnt,
  output logic [15:0]  tk_cnt
);

  localparam logic [6:0] BRANCH_OP = 7'b1100011;

  typedef enum logic [1:0] {IDLE, RESOLVE, HOLD, FLUSH} state_t;

  state_t       state;
  logic [2:0]   capFunct3;
  logic [N-1:0] capPc;
  logic [N-1:0] capImm;
  logic [2:0]   flushCnt;

  logic         resTaken;
  logic         resIllegal;
  logic [N-1:0] resTarget;

  // Branch condition and next-PC from the captured instruction and live comparator flags
  always_comb begin
    resTaken   = 1'b0;
    resIllegal = 1'b0;
    case (capFunct3)
      3'b000:         resTaken = BrEq;
      3'b001:         resTaken = !BrEq;
      3'b100, 3'b110: resTaken = BrLT;
      3'b101, 3'b111: resTaken = !BrLT;
      default:        resIllegal = 1'b1;
    endcase
    resTarget = resTaken ? (capPc + capImm) : (capPc + N'(4));
  end

  // Control FSM with all outputs registered; reset wins over every handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      taken     <= 1'b0;
      err       <= 1'b0;
      flush     <= 1'b0;
      BrUn      <= 1'b0;
      target    <= '0;
      br_cnt    <= '0;
      tk_cnt    <= '0;
      capFunct3 <= '0;
      capPc     <= '0;
      capImm    <= '0;
      flushCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Non-branch opcodes are consumed silently
          if (in_valid && opcode == BRANCH_OP) begin
            capFunct3 <= funct3;
            capPc     <= pc;
            capImm    <= imm;
            BrUn      <= funct3[1];
            in_ready  <= 1'b0;
            state     <= RESOLVE;
          end
        end
        RESOLVE: begin
          BrUn      <= 1'b0;
          taken     <= resTaken;
          target    <= resTarget;
          err       <= resIllegal | (resTaken && resTarget[1:0] != 2'b00);
          out_valid <= 1'b1;
          if (br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
          if (resTaken && tk_cnt != 16'hFFFF) tk_cnt <= tk_cnt + 16'd1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            taken     <= 1'b0;
            err       <= 1'b0;
            if (taken) begin
              flush    <= 1'b1;
              flushCnt <= 3'(FLUSH_CYC - 1);
              state    <= FLUSH;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flushCnt == 3'd0) begin
            flush    <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            flushCnt <= flushCnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: scoreboard queue filled by stimulus, drained by an output monitor.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
// Counter saturation is reached by preloading the counters near 16'hFFFF.
module tb_branch_ctrl;

  localparam int N         = 32;
  localparam int FLUSH_CYC = 2;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] ALU_OP = 7'b0110011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [N-1:0] pc;
  logic [N-1:0] imm;
  logic         BrEq;
  logic         BrLT;
  logic         BrUn;
  logic         out_valid;
  logic         out_ready;
  logic         taken;
  logic [N-1:0] target;
  logic         err;
  logic         flush;
  logic [15:0]  br_cnt;
  logic [15:0]  tk_cnt;

  branch_ctrl #(.N(N), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .pc(pc), .imm(imm),
    .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .target(target), .err(err), .flush(flush),
    .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic        e;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monExp;
  int          checks = 0;
  int          errors = 0;
  int          hsCount = 0;
  logic [15:0] expBr = 16'd0;
  logic [15:0] expTk = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result is checked against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hsCount++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: taken=%0b target=%h err=%0b with empty scoreboard", taken, target, err);
      end else begin
        monExp = sbq.pop_front();
        chk("mon_taken", {31'd0, taken}, {31'd0, monExp.tk});
        chk("mon_target", target, monExp.tgt);
        chk("mon_err", {31'd0, err}, {31'd0, monExp.e});
      end
    end
  end

  // One instruction through the block; hold = extra cycles of out_ready=0 in HOLD
  task automatic runBranch(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] p, input logic [31:0] i, input logic eq, input logic lt,
                           input logic eTk, input logic [31:0] eTgt, input logic eErr, input int hold);
    int hs0;
    hs0 = hsCount;
    chk({nm, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; opcode = op; funct3 = f3; pc = p; imm = i; BrEq = eq; BrLT = lt; out_ready = 1'b0;
    if (op == BR_OP) begin
      sbq.push_back('{eTk, eTgt, eErr});
      expBr = sat(expBr);
      if (eTk) expTk = sat(expTk);
    end
    tick();
    in_valid = 1'b0;
    if (op != BR_OP) begin
      chk({nm, "_consumed_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({nm, "_no_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_br_cnt"}, {16'd0, br_cnt}, {16'd0, expBr});
      return;
    end
    chk({nm, "_resolve_BrUn"}, {31'd0, BrUn}, {31'd0, f3[1]});
    chk({nm, "_resolve_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({nm, "_resolve_no_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({nm, "_latency_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_hold_BrUn"}, {31'd0, BrUn}, 32'd0);
    chk({nm, "_br_cnt"}, {16'd0, br_cnt}, {16'd0, expBr});
    chk({nm, "_tk_cnt"}, {16'd0, tk_cnt}, {16'd0, expTk});
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({nm, "_bp_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_bp_taken"}, {31'd0, taken}, {31'd0, eTk});
      chk({nm, "_bp_target"}, target, eTgt);
      chk({nm, "_bp_err"}, {31'd0, err}, {31'd0, eErr});
      chk({nm, "_bp_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_post_taken"}, {31'd0, taken}, 32'd0);
    chk({nm, "_post_err"}, {31'd0, err}, 32'd0);
    if (eTk) begin
      for (int k = 0; k < FLUSH_CYC; k++) begin
        chk({nm, "_flush_high"}, {31'd0, flush}, 32'd1);
        chk({nm, "_flush_in_ready"}, {31'd0, in_ready}, 32'd0);
        tick();
      end
    end
    chk({nm, "_flush_low"}, {31'd0, flush}, 32'd0);
    chk({nm, "_end_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_target_holds"}, target, eTgt);
    chk({nm, "_handshakes"}, hsCount, hs0 + 1);
  endtask

  // Watchdog: any stall ends the run with a failure line
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; pc = '0; imm = '0;
    BrEq = 1'b0; BrLT = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_BrUn", {31'd0, BrUn}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("rst_tk_cnt", {16'd0, tk_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    //          name      op      f3      pc            imm           eq    lt    tk    target        err   hold
    runBranch("beq",     BR_OP,  3'b000, 32'h100,      32'h20,       1'b1, 1'b0, 1'b1, 32'h120,      1'b0, 0);
    runBranch("bltu_nt", BR_OP,  3'b110, 32'h200,      32'h40,       1'b0, 1'b0, 1'b0, 32'h204,      1'b0, 0);
    runBranch("bne_bp",  BR_OP,  3'b001, 32'h300,      32'hFFFFFFF0, 1'b0, 1'b0, 1'b1, 32'h2F0,      1'b0, 5);
    runBranch("illegal", BR_OP,  3'b010, 32'h400,      32'h8,        1'b1, 1'b1, 1'b0, 32'h404,      1'b1, 0);
    runBranch("illeg11", BR_OP,  3'b011, 32'h404,      32'h8,        1'b0, 1'b1, 1'b0, 32'h408,      1'b1, 0);
    runBranch("misalgn", BR_OP,  3'b000, 32'h100,      32'h2,        1'b1, 1'b0, 1'b1, 32'h102,      1'b1, 0);
    runBranch("bge_wrap",BR_OP,  3'b101, 32'hFFFFFFFC, 32'h10,       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 0);
    runBranch("blt_tk",  BR_OP,  3'b100, 32'h10,       32'h8,        1'b0, 1'b1, 1'b1, 32'h18,       1'b0, 0);
    runBranch("bgeu_tk", BR_OP,  3'b111, 32'h20,       32'h4,        1'b0, 1'b0, 1'b1, 32'h24,       1'b0, 1);
    runBranch("alu_op",  ALU_OP, 3'b000, 32'h30,       32'h4,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 0);
    runBranch("beq_wrap",BR_OP,  3'b000, 32'hFFFFFFF0, 32'h20,       1'b1, 1'b0, 1'b1, 32'h10,       1'b0, 0);

    // Preload counters just below saturation, then cross the ceiling
    force dut.br_cnt = 16'hFFFE;
    force dut.tk_cnt = 16'hFFFE;
    #2;
    release dut.br_cnt;
    release dut.tk_cnt;
    expBr = 16'hFFFE;
    expTk = 16'hFFFE;
    runBranch("sat1",    BR_OP,  3'b000, 32'h40,       32'h4,        1'b1, 1'b0, 1'b1, 32'h44,       1'b0, 0);
    runBranch("sat2",    BR_OP,  3'b001, 32'h44,       32'h8,        1'b0, 1'b0, 1'b1, 32'h4C,       1'b0, 0);
    runBranch("sat3",    BR_OP,  3'b001, 32'h4C,       32'h8,        1'b1, 1'b0, 1'b0, 32'h50,       1'b0, 0);
    chk("sat_br_cnt", {16'd0, br_cnt}, 32'h0000FFFF);
    chk("sat_tk_cnt", {16'd0, tk_cnt}, 32'h0000FFFF);

    // Reset in the middle of FLUSH, with a new branch presented in the same cycle
    in_valid = 1'b1; opcode = BR_OP; funct3 = 3'b000; pc = 32'h500; imm = 32'h10; BrEq = 1'b1;
    sbq.push_back('{1'b1, 32'h510, 1'b0});
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rflush_flush_before", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick();
    chk("rflush_flush", {31'd0, flush}, 32'd0);
    chk("rflush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rflush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rflush_target", target, 32'd0);
    chk("rflush_br_cnt", {16'd0, br_cnt}, 32'd0);
    chk("rflush_tk_cnt", {16'd0, tk_cnt}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    expBr = 16'd0;
    expTk = 16'd0;
    tick();
    chk("rflush_still_idle", {31'd0, in_ready}, 32'd1);
    runBranch("post_rst",BR_OP,  3'b110, 32'h600,      32'h40,       1'b0, 1'b1, 1'b1, 32'h640,      1'b0, 0);

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
